// File: rtl/guess_pkg.sv
// Shared constants and types for the four-digit guess entry block.
package guess_pkg;

    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned DIGIT_W_DEF = 3;
    localparam int unsigned NUM_BTNS    = 4;

    typedef logic [NUM_DIGITS-1:0][DIGIT_W_DEF-1:0] digit_arr_t;

    typedef enum logic [1:0] {
        BTN_LEFT  = 2'd0,
        BTN_RIGHT = 2'd1,
        BTN_UP    = 2'd2,
        BTN_DOWN  = 2'd3
    } btn_e;

endpackage

// File: rtl/guess_edge.sv
// Button input register (optional 2-flop sync via GUESS_ENTRY_SYNC_EN) plus rising-edge detector.
module guess_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic press_c
);

    logic samp_d;
    logic samp_q;
    logic prev_q;

`ifdef GUESS_ENTRY_SYNC_EN
    localparam int unsigned VLD_W = 4;
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], level};
    end

    assign samp_d = sync_q[1];
`else
    localparam int unsigned VLD_W = 2;
    assign samp_d = level;
`endif

    // Marks when prev_q holds a real post-reset sample, so a button held through reset is not a press.
    logic [VLD_W-1:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= 1'b0;
            prev_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            samp_q <= samp_d;
            prev_q <= samp_q;
            vld_q  <= {vld_q[VLD_W-2:0], 1'b1};
        end
    end

    assign press_c = samp_q & ~prev_q & vld_q[VLD_W-1];

endmodule

// File: rtl/guess_entry.sv
// Four-digit code entry: selection counter and digit registers driven by button presses.
// Build option GUESS_ENTRY_SYNC_EN adds two-flop synchronizers on buttons and enable.
module guess_entry
    import guess_pkg::*;
#(
    parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               left,
    input  logic               right,
    input  logic               up,
    input  logic               down,
    output logic [DIGIT_W-1:0] led_zero,
    output logic [DIGIT_W-1:0] led_one,
    output logic [DIGIT_W-1:0] led_two,
    output logic [DIGIT_W-1:0] led_three,
    output logic [SEL_W-1:0]   blink_led
);

    logic [NUM_BTNS-1:0] btn_lvl;
    logic [NUM_BTNS-1:0] press_c;
    logic                en_act;

    assign btn_lvl[BTN_LEFT]  = left;
    assign btn_lvl[BTN_RIGHT] = right;
    assign btn_lvl[BTN_UP]    = up;
    assign btn_lvl[BTN_DOWN]  = down;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        guess_edge u_edge (
            .clk     (clk),
            .rst_n   (rst_n),
            .level   (btn_lvl[i]),
            .press_c (press_c[i])
        );
    end

`ifdef GUESS_ENTRY_SYNC_EN
    logic [1:0] en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= '0;
        else        en_q <= {en_q[0], enable};
    end

    assign en_act = en_q[1];
`else
    logic en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_q <= 1'b0;
        else        en_q <= enable;
    end

    assign en_act = en_q;
`endif

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digit_d;
    logic [SEL_W-1:0]                   sel_q;
    logic [SEL_W-1:0]                   sel_d;

    // Digit update uses the selection held before this edge; opposing presses cancel.
    always_comb begin
        digit_d = digit_q;
        sel_d   = sel_q;
        if (en_act) begin
            if (press_c[BTN_UP] && !press_c[BTN_DOWN]) begin
                digit_d[sel_q] = digit_q[sel_q] + DIGIT_W'(1);
            end else if (press_c[BTN_DOWN] && !press_c[BTN_UP]) begin
                digit_d[sel_q] = digit_q[sel_q] - DIGIT_W'(1);
            end
            if (press_c[BTN_RIGHT] && !press_c[BTN_LEFT]) begin
                sel_d = sel_q + SEL_W'(1);
            end else if (press_c[BTN_LEFT] && !press_c[BTN_RIGHT]) begin
                sel_d = sel_q - SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            sel_q   <= '0;
        end else begin
            digit_q <= digit_d;
            sel_q   <= sel_d;
        end
    end

    assign led_zero  = digit_q[0];
    assign led_one   = digit_q[1];
    assign led_two   = digit_q[2];
    assign led_three = digit_q[3];
    assign blink_led = sel_q;

endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry: directed vector table, corner sequences, random vs. model.
module tb_guess_entry;

    localparam int unsigned DW  = 3;
    localparam int          MOD = 1 << DW;
`ifdef GUESS_ENTRY_SYNC_EN
    localparam int LAT   = 3;
    localparam int ENLAT = 2;
`else
    localparam int LAT   = 1;
    localparam int ENLAT = 1;
`endif

    localparam logic [3:0] B_NONE  = 4'b0000;
    localparam logic [3:0] B_LEFT  = 4'b0001;
    localparam logic [3:0] B_RIGHT = 4'b0010;
    localparam logic [3:0] B_UP    = 4'b0100;
    localparam logic [3:0] B_DOWN  = 4'b1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic [DW-1:0] led_zero, led_one, led_two, led_three;
    logic [1:0]    blink_led;

    guess_entry #(.DIGIT_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .left      (left),
        .right     (right),
        .up        (up),
        .down      (down),
        .led_zero  (led_zero),
        .led_one   (led_one),
        .led_two   (led_two),
        .led_three (led_three),
        .blink_led (blink_led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-edge history of sampled levels since reset.
    int         m_dig [4];
    int         m_sel;
    int         cnt;
    logic [3:0] hist [6];
    logic       en_hist [6];

    task automatic model_edge();
        logic [3:0] p;
        int s;
        if (!rst_n) begin
            cnt = 0;
            m_sel = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            return;
        end
        for (int i = 5; i > 0; i--) begin
            hist[i]    = hist[i-1];
            en_hist[i] = en_hist[i-1];
        end
        hist[0]    = {down, up, right, left};
        en_hist[0] = enable;
        cnt++;
        if (cnt >= LAT + 2 && en_hist[ENLAT]) begin
            p = hist[LAT] & ~hist[LAT+1];
            s = m_sel;
            if (p[2] && !p[3]) m_dig[s] = (m_dig[s] + 1) % MOD;
            if (p[3] && !p[2]) m_dig[s] = (m_dig[s] + MOD - 1) % MOD;
            if (p[1] && !p[0]) m_sel = (m_sel + 1) % 4;
            if (p[0] && !p[1]) m_sel = (m_sel + 3) % 4;
        end
    endtask

    task automatic tick(input logic [3:0] btn, input logic en);
        @(negedge clk);
        {down, up, right, left} = btn;
        enable = en;
        @(posedge clk);
        model_edge();
    endtask

    task automatic check(input string name, input int e0, input int e1, input int e2,
                         input int e3, input int eb);
        #1;
        checks++;
        if (led_zero !== DW'(e0) || led_one !== DW'(e1) || led_two !== DW'(e2) ||
            led_three !== DW'(e3) || blink_led !== 2'(eb)) begin
            errors++;
            $display("FAIL %s: leds %0d-%0d-%0d-%0d blink %0d, expected %0d-%0d-%0d-%0d blink %0d",
                     name, led_zero, led_one, led_two, led_three, blink_led, e0, e1, e2, e3, eb);
        end
    endtask

    // Asserts reset (checking the immediate clear), then releases with buttons at 'held'.
    task automatic do_reset(input logic [3:0] held);
        @(negedge clk);
        rst_n = 1'b0;
        {down, up, right, left} = held;
        enable = 1'b1;
        check("rst_async", 0, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        repeat (5) tick(held, 1'b1);
        check("rst_held", 0, 0, 0, 0, 0);
    endtask

    task automatic press(input logic [3:0] btn, input logic en);
        repeat (2) tick(btn, en);
        repeat (4) tick(B_NONE, en);
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [3:0] btn;
        int         reps;
        int         e0, e1, e2, e3, eb;
    } vec_t;

    vec_t vecs [17];

    initial begin
        logic [3:0] rb;
        logic       re;

        vecs[0]  = '{0, 1, B_NONE,           1, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, B_RIGHT,          1, 0, 0, 0, 0, 1};
        vecs[2]  = '{0, 1, B_UP,             1, 0, 1, 0, 0, 1};
        vecs[3]  = '{0, 1, B_RIGHT,          2, 0, 1, 0, 0, 3};
        vecs[4]  = '{0, 1, B_UP,             9, 0, 1, 0, 1, 3};
        vecs[5]  = '{1, 1, B_LEFT,           1, 0, 0, 0, 0, 3};
        vecs[6]  = '{0, 1, B_DOWN,           1, 0, 0, 0, 7, 3};
        vecs[7]  = '{0, 1, B_RIGHT,          1, 0, 0, 0, 7, 0};
        vecs[8]  = '{0, 0, B_NONE,           1, 0, 0, 0, 7, 0};
        vecs[9]  = '{0, 0, B_UP,             1, 0, 0, 0, 7, 0};
        vecs[10] = '{0, 0, B_RIGHT,          1, 0, 0, 0, 7, 0};
        vecs[11] = '{0, 1, B_NONE,           1, 0, 0, 0, 7, 0};
        vecs[12] = '{0, 1, B_LEFT | B_RIGHT, 1, 0, 0, 0, 7, 0};
        vecs[13] = '{0, 1, B_UP | B_DOWN,    1, 0, 0, 0, 7, 0};
        vecs[14] = '{0, 1, B_UP | B_RIGHT,   1, 1, 0, 0, 7, 1};
        vecs[15] = '{0, 1, B_LEFT,           1, 1, 0, 0, 7, 0};
        vecs[16] = '{0, 1, B_DOWN,           2, 7, 0, 0, 7, 0};

        #2;
        check("reset", 0, 0, 0, 0, 0);
        do_reset(B_NONE);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst) do_reset(B_NONE);
            repeat (vecs[i].reps) press(vecs[i].btn, vecs[i].en);
            check($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2,
                  vecs[i].e3, vecs[i].eb);
        end

        // Up held across the enable rise is not a press; a fresh press is.
        repeat (3) tick(B_UP, 1'b0);
        repeat (6) tick(B_UP, 1'b1);
        check("held_at_enable", 7, 0, 0, 7, 0);
        repeat (2) tick(B_NONE, 1'b1);
        press(B_UP, 1'b1);
        check("repress_after_enable", 0, 0, 0, 7, 0);

        // Single-sample pulses with single-sample gaps each count.
        tick(B_UP, 1'b1);
        tick(B_NONE, 1'b1);
        tick(B_UP, 1'b1);
        repeat (5) tick(B_NONE, 1'b1);
        check("back_to_back", 2, 0, 0, 7, 0);

        // Reset with a press in flight; button still held after release.
        tick(B_RIGHT, 1'b1);
        do_reset(B_RIGHT);
        repeat (2) tick(B_NONE, 1'b1);
        press(B_RIGHT, 1'b1);
        check("press_after_reset", 0, 0, 0, 0, 1);

        // Random levels against the reference model.
        rb = B_NONE;
        re = 1'b1;
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 2) == 0) rb[b] = ~rb[b];
            end
            if ($urandom_range(0, 19) == 0) re = ~re;
            tick(rb, re);
            check("random", m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_sel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
